// File: rtl/mips_cpu_seq_pkg.sv
// Shared types for the MIPS CPU phase sequencer.
//   seq_state_e : major state (HALT, FETCH, EXEC, STALL)
//   phase_idx_t : index of the current execute phase
//   phase_t     : full sequencer position = major state + execute index
//   MAX_EXEC    : largest supported number of execute phases
package mips_cpu_seq_pkg;

    localparam int MAX_EXEC = 4;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_STALL = 2'd3
    } seq_state_e;

    typedef logic [$clog2(MAX_EXEC)-1:0] phase_idx_t;

    typedef struct packed {
        seq_state_e st;
        phase_idx_t idx;
    } phase_t;

endpackage

// File: rtl/mips_cpu_sat_counter.sv
// Saturating up-counter used for the sequencer performance counters.
// Ports:
//   clk   in   system clock
//   reset in   synchronous active-high clear
//   inc   in   count one event this cycle
//   count out  current value; sticks at all-ones instead of wrapping
module mips_cpu_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mips_cpu_phase_sequencer.sv
// CPU control sequencer: FETCH followed by up to NUM_EXEC execute phases, with a
// memory-wait stall that returns to the interrupted phase, a halt state left only
// by reset, and early instruction completion via skip_exec.
// Optional feature: define MIPS_CPU_SEQ_PERF_EN to build saturating performance
// counters; otherwise instr_count and stall_cycles are constant 0.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   halt         in   halt request, honoured in FETCH only
//   waitrequest  in   memory busy, freezes the current phase
//   skip_exec    in   current execute phase is the last of this instruction
//   active       out  low only in HALT
//   phase_f      out  high in FETCH
//   phase_exec   out  one-hot execute phase strobes
//   stalled      out  high in STALL
//   instr_done   out  one-cycle pulse in the first FETCH after retirement
//   instr_count  out  retired instruction count (perf)
//   stall_cycles out  cycles spent stalled (perf)
module mips_cpu_phase_sequencer
    import mips_cpu_seq_pkg::*;
#(
    parameter int NUM_EXEC = 2,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                halt,
    input  logic                waitrequest,
    input  logic                skip_exec,
    output logic                active,
    output logic                phase_f,
    output logic [NUM_EXEC-1:0] phase_exec,
    output logic                stalled,
    output logic                instr_done,
    output logic [CNT_W-1:0]    instr_count,
    output logic [CNT_W-1:0]    stall_cycles
);

    localparam phase_idx_t LAST_IDX = phase_idx_t'(NUM_EXEC - 1);
    localparam phase_t     POS_FETCH = '{st: ST_FETCH, idx: '0};

    phase_t cur;
    phase_t nxt;
    phase_t ret_phase;
    phase_t ret_nxt;
    logic   done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= POS_FETCH;
            ret_phase  <= POS_FETCH;
            instr_done <= 1'b0;
        end else begin
            cur        <= nxt;
            ret_phase  <= ret_nxt;
            instr_done <= done_nxt;
        end
    end

    always_comb begin
        nxt      = cur;
        ret_nxt  = ret_phase;
        done_nxt = 1'b0;
        case (cur.st)
            ST_FETCH: begin
                if (waitrequest) begin
                    nxt     = '{st: ST_STALL, idx: cur.idx};
                    ret_nxt = cur;
                end else if (halt) begin
                    nxt = '{st: ST_HALT, idx: '0};
                end else begin
                    nxt = '{st: ST_EXEC, idx: '0};
                end
            end
            ST_EXEC: begin
                if (waitrequest) begin
                    nxt     = '{st: ST_STALL, idx: cur.idx};
                    ret_nxt = cur;
                end else if (skip_exec || (cur.idx == LAST_IDX)) begin
                    nxt      = POS_FETCH;
                    done_nxt = 1'b1;
                end else begin
                    nxt = '{st: ST_EXEC, idx: cur.idx + phase_idx_t'(1)};
                end
            end
            ST_STALL: begin
                // The interrupted phase is re-entered, so its work is redone.
                if (!waitrequest) begin
                    nxt = ret_phase;
                end
            end
            default: begin
                nxt = cur;
            end
        endcase
    end

    always_comb begin
        active     = (cur.st != ST_HALT);
        phase_f    = (cur.st == ST_FETCH);
        stalled    = (cur.st == ST_STALL);
        phase_exec = '0;
        for (int k = 0; k < NUM_EXEC; k++) begin
            phase_exec[k] = (cur.st == ST_EXEC) && (cur.idx == phase_idx_t'(k));
        end
    end

`ifdef MIPS_CPU_SEQ_PERF_EN
    logic stall_inc;
    assign stall_inc = (cur.st == ST_STALL);

    mips_cpu_sat_counter #(.WIDTH(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (done_nxt),
        .count (instr_count)
    );

    mips_cpu_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cycles)
    );
`else
    assign instr_count  = '0;
    assign stall_cycles = '0;
`endif

endmodule
